// File: rtl/dpll_pkg.sv
// Shared definitions for the PI loop filter: FSM encoding, centre code,
// saturation limits and the saturating window-error step.
package dpll_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCUM  = 2'd1,
        ST_UPDATE = 2'd2,
        ST_HOLD   = 2'd3
    } dpll_state_e;

    localparam logic [15:0] CTRL_MID_DEF = 16'h8000;

    localparam int ERR_W   = 9;
    localparam int INTEG_W = 17;
    localparam int SUM_W   = 20;
    localparam int CNT_W   = 8;

    localparam logic signed [ERR_W-1:0]   ERR_MAX   = 9'sd127;
    localparam logic signed [ERR_W-1:0]   ERR_MIN   = -9'sd127;
    localparam logic signed [INTEG_W-1:0] INTEG_MAX = 17'sd32767;
    localparam logic signed [INTEG_W-1:0] INTEG_MIN = -17'sd32767;

    typedef struct packed {
        logic signed [ERR_W-1:0] val;
        logic                    clamped;
    } err_step_t;

    // One cycle of window-error accumulation; simultaneous up/down cancel.
    function automatic err_step_t err_step(
        input logic signed [ERR_W-1:0] err,
        input logic                    inc,
        input logic                    dec
    );
        err_step_t r;
        r.val     = err;
        r.clamped = 1'b0;
        if (inc && !dec) begin
            if (err >= ERR_MAX) begin
                r.clamped = 1'b1;
            end else begin
                r.val = err + 9'sd1;
            end
        end else if (dec && !inc) begin
            if (err <= ERR_MIN) begin
                r.clamped = 1'b1;
            end else begin
                r.val = err - 9'sd1;
            end
        end else begin
            r.val = err;
        end
        return r;
    endfunction

endpackage

// File: rtl/dpll_pulse_sync.sv
// Two-flop synchroniser for an asynchronous PFD pulse followed by a
// rising-edge detector; event_o is a single clk-cycle pulse.
module dpll_pulse_sync (
    input  logic clk,
    input  logic rst,
    input  logic async_i,
    output logic event_o
);

    logic [2:0] sync_q;

    // Shift the raw input through the synchroniser and edge-history flop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= 3'b000;
        end else begin
            sync_q <= {sync_q[1:0], async_i};
        end
    end

    assign event_o = sync_q[1] & ~sync_q[2];

endmodule

// File: rtl/dpll_pi_loop_filter.sv
// Windowed PI loop filter for a DPLL: counts PFD up/down events over a
// fixed window and converts them into a clamped DCO control word.
module dpll_pi_loop_filter
    import dpll_pkg::*;
#(
    parameter int                CTRL_W   = 16,
    parameter int                WIN_LEN  = 16,
    parameter int                KP_SHIFT = 3,
    parameter logic [CTRL_W-1:0] CTRL_MID = CTRL_MID_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              up,
    input  logic              down,
    input  logic              hold,
    output logic [CTRL_W-1:0] control_out,
    output logic              control_valid,
    output logic              sat_flag
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIN_LEN - 1);
    localparam logic signed [SUM_W-1:0] SUM_MAX = SUM_W'((64'd1 << CTRL_W) - 64'd1);
    localparam logic signed [INTEG_W:0] INTEG_SUM_MAX = {INTEG_MAX[INTEG_W-1], INTEG_MAX};
    localparam logic signed [INTEG_W:0] INTEG_SUM_MIN = {INTEG_MIN[INTEG_W-1], INTEG_MIN};

    logic up_ev_s;
    logic dn_ev_s;

    dpll_state_e               state_q, state_d;
    logic [CNT_W-1:0]          cnt_q, cnt_d;
    logic signed [ERR_W-1:0]   err_q, err_d;
    logic signed [INTEG_W-1:0] integ_q, integ_d;
    logic [CTRL_W-1:0]         out_q, out_d;
    logic                      valid_q, valid_d;
    logic                      sat_q, sat_d;
    logic                      win_sat_q, win_sat_d;

    err_step_t                 step_acc_s;
    err_step_t                 step_new_s;
    logic signed [INTEG_W:0]   integ_sum_s;
    logic signed [INTEG_W-1:0] integ_sat_s;
    logic                      integ_clamp_s;
    logic signed [SUM_W-1:0]   mid_ext_s;
    logic signed [SUM_W-1:0]   err_ext_s;
    logic signed [SUM_W-1:0]   integ_ext_s;
    logic signed [SUM_W-1:0]   sum_s;
    logic [CTRL_W-1:0]         out_sat_s;
    logic                      out_clamp_s;

    dpll_pulse_sync u_sync_up (
        .clk     (clk),
        .rst     (rst),
        .async_i (up),
        .event_o (up_ev_s)
    );

    dpll_pulse_sync u_sync_dn (
        .clk     (clk),
        .rst     (rst),
        .async_i (down),
        .event_o (dn_ev_s)
    );

    // step_new_s seeds the next window with an event landing in the UPDATE cycle.
    assign step_acc_s = err_step(err_q, up_ev_s, dn_ev_s);
    assign step_new_s = err_step({ERR_W{1'b0}}, up_ev_s, dn_ev_s);

    assign integ_sum_s = {integ_q[INTEG_W-1], integ_q}
                       + {{(INTEG_W + 1 - ERR_W){err_q[ERR_W-1]}}, err_q};

    // Integrator saturation at +/-32767.
    always_comb begin
        integ_sat_s   = integ_sum_s[INTEG_W-1:0];
        integ_clamp_s = 1'b0;
        if (integ_sum_s > INTEG_SUM_MAX) begin
            integ_sat_s   = INTEG_MAX;
            integ_clamp_s = 1'b1;
        end else if (integ_sum_s < INTEG_SUM_MIN) begin
            integ_sat_s   = INTEG_MIN;
            integ_clamp_s = 1'b1;
        end else begin
            integ_sat_s   = integ_sum_s[INTEG_W-1:0];
            integ_clamp_s = 1'b0;
        end
    end

    assign mid_ext_s   = {{(SUM_W - CTRL_W){1'b0}}, CTRL_MID};
    assign err_ext_s   = {{(SUM_W - ERR_W){err_q[ERR_W-1]}}, err_q} <<< KP_SHIFT;
    assign integ_ext_s = {{(SUM_W - INTEG_W){integ_sat_s[INTEG_W-1]}}, integ_sat_s};
    assign sum_s       = mid_ext_s + err_ext_s + integ_ext_s;

    // Clamp the proportional + integral sum into the unsigned DCO code range.
    always_comb begin
        out_sat_s   = sum_s[CTRL_W-1:0];
        out_clamp_s = 1'b0;
        if (sum_s[SUM_W-1]) begin
            out_sat_s   = {CTRL_W{1'b0}};
            out_clamp_s = 1'b1;
        end else if (sum_s > SUM_MAX) begin
            out_sat_s   = {CTRL_W{1'b1}};
            out_clamp_s = 1'b1;
        end else begin
            out_sat_s   = sum_s[CTRL_W-1:0];
            out_clamp_s = 1'b0;
        end
    end

    // Next-state logic; hold pre-empts both accumulation and the update itself.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        err_d     = err_q;
        integ_d   = integ_q;
        out_d     = out_q;
        valid_d   = 1'b0;
        sat_d     = sat_q;
        win_sat_d = win_sat_q;
        case (state_q)
            ST_IDLE: begin
                state_d   = ST_ACCUM;
                cnt_d     = {CNT_W{1'b0}};
                err_d     = {ERR_W{1'b0}};
                win_sat_d = 1'b0;
            end
            ST_ACCUM: begin
                if (hold) begin
                    state_d   = ST_HOLD;
                    cnt_d     = {CNT_W{1'b0}};
                    err_d     = {ERR_W{1'b0}};
                    win_sat_d = 1'b0;
                end else begin
                    err_d     = step_acc_s.val;
                    win_sat_d = win_sat_q | step_acc_s.clamped;
                    if (cnt_q == CNT_LAST) begin
                        state_d = ST_UPDATE;
                        cnt_d   = {CNT_W{1'b0}};
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end
            end
            ST_UPDATE: begin
                if (hold) begin
                    state_d   = ST_HOLD;
                    cnt_d     = {CNT_W{1'b0}};
                    err_d     = {ERR_W{1'b0}};
                    win_sat_d = 1'b0;
                end else begin
                    state_d   = ST_ACCUM;
                    cnt_d     = {CNT_W{1'b0}};
                    integ_d   = integ_sat_s;
                    out_d     = out_sat_s;
                    valid_d   = 1'b1;
                    sat_d     = win_sat_q | integ_clamp_s | out_clamp_s;
                    err_d     = step_new_s.val;
                    win_sat_d = step_new_s.clamped;
                end
            end
            ST_HOLD: begin
                cnt_d     = {CNT_W{1'b0}};
                err_d     = {ERR_W{1'b0}};
                win_sat_d = 1'b0;
                if (!hold) begin
                    state_d = ST_ACCUM;
                end else begin
                    state_d = ST_HOLD;
                end
            end
            default: begin
                state_d   = ST_IDLE;
                cnt_d     = {CNT_W{1'b0}};
                err_d     = {ERR_W{1'b0}};
                win_sat_d = 1'b0;
            end
        endcase
    end

    // FSM and datapath registers; outputs come straight from flops.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= {CNT_W{1'b0}};
            err_q     <= {ERR_W{1'b0}};
            integ_q   <= {INTEG_W{1'b0}};
            out_q     <= CTRL_MID;
            valid_q   <= 1'b0;
            sat_q     <= 1'b0;
            win_sat_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            err_q     <= err_d;
            integ_q   <= integ_d;
            out_q     <= out_d;
            valid_q   <= valid_d;
            sat_q     <= sat_d;
            win_sat_q <= win_sat_d;
        end
    end

    assign control_out   = out_q;
    assign control_valid = valid_q;
    assign sat_flag      = sat_q;

endmodule
